// File: rtl/register_parallel_unload_serial_pkg.sv
// Shared definitions for the parallel-in / serial-out unload register.
// Holds the FSM state type, the default word width and the helper that
// sizes the bit counter.
package register_serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int ANCHO_DEF = 8;

  // The counter must be able to hold ANCHO when the parity bit is enabled.
  function automatic int cnt_width(input int ancho);
    return $clog2(ancho + 1);
  endfunction

endpackage

// File: rtl/register_parallel_unload_serial_if.sv
// Bus between a word producer and the serial unload register.
//
// Handshake: carga is the request and listo is the ready. A word is
// transferred on every rising edge where carga=1 and listo=1; carga is
// ignored (and In not sampled) whenever listo=0, so the producer may hold
// or drop it freely. Q/valido/fin form a push-only stream with no back
// pressure: valido qualifies Q and fin marks the final bit of the word.
interface register_parallel_unload_serial_if #(
  parameter int ANCHO = register_serial_pkg::ANCHO_DEF
);
  logic             carga;
  logic [ANCHO-1:0] In;
  logic             listo;
  logic             Q;
  logic             valido;
  logic             fin;

  modport master (output carga, output In,
                  input listo, input Q, input valido, input fin);
  modport slave  (input carga, input In,
                  output listo, output Q, output valido, output fin);
endinterface

// File: rtl/register_parallel_unload_serial_contador_bits.sv
// Up-counter with synchronous reset, clear and enable. It saturates at
// TERMINAL (never wraps) and flags when it sits on that value.
module contador_bits #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] TC = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear wins over enable; hold once the terminal value is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TC)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign tc_o    = (cnt_q == TC);

endmodule

// File: rtl/register_parallel_unload_serial.sv
// Parallel-in, serial-out unload register. Captures an ANCHO-bit word when
// carga is accepted and shifts it out MSB-first on Q, one bit per clock.
// Optional macro PISO_PARITY_EN appends an even-parity bit after the data
// bits; fin then marks the parity bit instead of the last data bit.
module register_parallel_unload_serial
  import register_serial_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic                               clk,
  input  logic                               reset,
  register_parallel_unload_serial_if.slave   bus,
  output state_t                             state_o
);

  localparam int CW = cnt_width(ANCHO);
`ifdef PISO_PARITY_EN
  localparam int LAST = ANCHO;
`else
  localparam int LAST = ANCHO - 1;
`endif

  state_t           state_q, state_d;
  logic [ANCHO-1:0] sh_q, sh_d;
  logic             q_q, q_d;
  logic             valido_q, valido_d;
  logic [CW-1:0]    count_w;
  logic             tc_w;
  logic             cnt_clr, cnt_en;
  logic             fin_w, listo_w, accept;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`else
  logic             unused_count;
  assign unused_count = ^count_w;
`endif

  contador_bits #(
    .WIDTH    (CW),
    .TERMINAL (LAST)
  ) u_contador (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (count_w),
    .tc_o    (tc_w)
  );

  assign fin_w   = valido_q && tc_w;
  assign listo_w = (state_q == IDLE) || fin_w;
  assign accept  = bus.carga && listo_w;

  // Next state: accept a new word (also back-to-back on fin), retire after
  // the last bit, otherwise keep shifting.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    q_d      = q_q;
    valido_d = valido_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
`ifdef PISO_PARITY_EN
    par_d    = par_q;
`endif
    if (accept) begin
      state_d  = SHIFT;
      q_d      = bus.In[ANCHO-1];
      sh_d     = {bus.In[ANCHO-2:0], 1'b0};
      valido_d = 1'b1;
      cnt_clr  = 1'b1;
`ifdef PISO_PARITY_EN
      par_d    = ^bus.In;
`endif
    end else if (fin_w) begin
      state_d  = IDLE;
      q_d      = 1'b0;
      valido_d = 1'b0;
      cnt_clr  = 1'b1;
    end else if (state_q == SHIFT) begin
      cnt_en = 1'b1;
      sh_d   = {sh_q[ANCHO-2:0], 1'b0};
`ifdef PISO_PARITY_EN
      // After the last data bit the stored parity takes the Q slot.
      if (count_w == CW'(ANCHO - 1)) q_d = par_q;
      else                           q_d = sh_q[ANCHO-1];
`else
      q_d = sh_q[ANCHO-1];
`endif
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      q_q      <= 1'b0;
      valido_q <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      q_q      <= q_d;
      valido_q <= valido_d;
`ifdef PISO_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign bus.listo  = listo_w;
  assign bus.Q      = q_q;
  assign bus.valido = valido_q;
  assign bus.fin    = fin_w;
  assign state_o    = state_q;

endmodule

// File: tb/tb_register_parallel_unload_serial.sv
// Directed bench for the serial unload register: reset state, single word,
// back-to-back words, ignored carga while busy, reset mid-word and, when
// PISO_PARITY_EN is defined, the trailing parity bit.
module tb_register_parallel_unload_serial;
  import register_serial_pkg::*;

  localparam int ANCHO = 8;
`ifdef PISO_PARITY_EN
  localparam int NB = ANCHO + 1;
`else
  localparam int NB = ANCHO;
`endif

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset;
  state_t dbg_state;

  always #5 clk = ~clk;

  register_parallel_unload_serial_if #(.ANCHO(ANCHO)) bus ();

  register_parallel_unload_serial #(.ANCHO(ANCHO)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         total = 0;
  int         bad   = 0;
  logic [0:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected serial stream of one word: MSB first, then parity if enabled.
  task automatic push_word(input logic [ANCHO-1:0] w);
    for (int i = ANCHO - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef PISO_PARITY_EN
    exp_q.push_back(^w);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_listo"},  bus.listo,  1);
    check_eq({tag, "_valido"}, bus.valido, 0);
    check_eq({tag, "_q"},      bus.Q,      0);
    check_eq({tag, "_fin"},    bus.fin,    0);
    check_eq({tag, "_state"},  dbg_state,  IDLE);
  endtask

  task automatic load(input string tag, input logic [ANCHO-1:0] w);
    check_eq({tag, "_listo_pre"}, bus.listo, 1);
    bus.carga = 1'b1;
    bus.In    = w;
    push_word(w);
    tick();
    bus.carga = 1'b0;
  endtask

  // Compare the current Q cycle against the head of the expected queue.
  task automatic drain_bit(input string tag, input bit last);
    logic [0:0] eb;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_underflow: got=valid bit expected=no bit", tag);
    end else begin
      eb = exp_q.pop_front();
      check_eq({tag, "_q"}, bus.Q, eb);
    end
    check_eq({tag, "_valido"}, bus.valido, 1);
    check_eq({tag, "_fin"},    bus.fin,    last);
  endtask

  task automatic stream(input string tag);
    for (int i = 1; i <= NB; i++) begin
      drain_bit(tag, i == NB);
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    bus.carga = 1'b0;
    bus.In    = '0;
    tick();
    tick();
    check_idle("rst");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle("idle");
    end

    // Single word 8'hA5: 1,0,1,0,0,1,0,1 then idle.
    load("a5", 8'hA5);
    stream("a5");
    check_idle("a5_end");

    // Back-to-back: 8'h3C accepted on the fin cycle of 8'hA5.
    load("b2b_a", 8'hA5);
    for (int i = 1; i <= NB; i++) begin
      drain_bit("b2b_a", i == NB);
      if (i == NB) begin
        check_eq("b2b_listo_fin", bus.listo, 1);
        bus.carga = 1'b1;
        bus.In    = 8'h3C;
        push_word(8'h3C);
      end
      tick();
      bus.carga = 1'b0;
    end
    stream("b2b_b");
    check_idle("b2b_end");

    // carga with 8'hFF during cycles 2..5 of an 8'h00 word is ignored.
    load("ign", 8'h00);
    for (int i = 1; i <= NB; i++) begin
      drain_bit("ign", i == NB);
      check_eq("ign_listo", bus.listo, (i == NB) ? 1 : 0);
      if (i >= 2 && i <= 5) begin
        bus.carga = 1'b1;
        bus.In    = 8'hFF;
      end else begin
        bus.carga = 1'b0;
      end
      tick();
    end
    bus.carga = 1'b0;
    check_idle("ign_end");
    check_eq("ign_q_empty", exp_q.size(), 0);

    // Reset on the 3rd bit of 8'hA5 aborts the word.
    load("rstmid", 8'hA5);
    drain_bit("rstmid", 1'b0);
    tick();
    drain_bit("rstmid", 1'b0);
    tick();
    drain_bit("rstmid", 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("rstmid_abort");
    exp_q.delete();
    load("r81", 8'h81);
    stream("r81");
    check_idle("r81_end");

`ifdef PISO_PARITY_EN
    // Parity bit values: A5 has even weight -> 0, 07 has odd weight -> 1.
    load("par_a5", 8'hA5);
    for (int i = 1; i <= NB; i++) begin
      drain_bit("par_a5", i == NB);
      if (i == NB) check_eq("par_a5_bit9", bus.Q, 0);
      tick();
    end
    check_idle("par_a5_end");
    load("par_07", 8'h07);
    for (int i = 1; i <= NB; i++) begin
      drain_bit("par_07", i == NB);
      if (i == NB) check_eq("par_07_bit9", bus.Q, 1);
      tick();
    end
    check_idle("par_07_end");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_parallel_unload_serial.md
Name: register_parallel_unload_serial

Overview:
- Parallel-in, serial-out register: the unload end of the parallel-load register path.
- Captures an ANCHO-bit word in one clock when carga is accepted.
- Shifts the word out MSB-first, one bit per clock, on Q.
- valido qualifies each bit; fin marks the last bit of each word.
- Feeds serial links and any block that consumes a stored word bit by bit.

Parameters:
- ANCHO, 8, data word width in bits; legal range ANCHO >= 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- carga  input  1  load request; accepted only when listo=1.
- In  input  ANCHO  parallel data word, sampled when carga is accepted.
- listo  output  1  block can accept carga in this cycle.
- Q  output  1  serial data bit, registered.
- valido  output  1  Q holds a valid bit this cycle, registered.
- fin  output  1  current Q bit is the last bit of the word.

Behaviour:
- Reset values: state=IDLE, shift register=0, count=0, Q=0, valido=0; therefore fin=0 and listo=1.
- Reset has priority over all other inputs.
- Reset asserted mid-word aborts the word immediately; the remaining bits are never emitted.
- States:
  - IDLE: no transfer in progress.
  - SHIFT: word being emitted.
- Accept condition: carga=1 and listo=1 at a rising edge.
- listo = (state==IDLE) or fin.
- On accept:
  - Q<=In[ANCHO-1], valido<=1.
  - Shift register <= In shifted left by 1.
  - count<=0; state<=SHIFT.
- Latency: first bit appears on Q one cycle after the accepting edge.
- SHIFT step, each edge with count<ANCHO-1:
  - Q<=shift register MSB; shift register shifts left by 1, filling 0.
  - count<=count+1.
- Last bit: fin = valido and (count==ANCHO-1), combinational from registers.
- Edge while fin=1:
  - If carga=1, accept the new word (back-to-back, no idle gap).
  - Otherwise valido<=0, Q<=0, state<=IDLE.
- carga while listo=0 is ignored and In is not sampled; the in-flight word is not corrupted.
- One word occupies exactly ANCHO cycles of valido=1.
- Counter width: $clog2(ANCHO+1). The counter never wraps past ANCHO-1.
- In IDLE: Q=0 and valido=0.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After data bit ANCHO-1, one extra cycle emits the even-parity bit (XOR of the captured word) with valido=1.
  - fin moves to the parity bit; a word takes ANCHO+1 cycles.
  - The parity value is computed and stored at accept.
- Undefined: no parity logic; behaviour exactly as above.

Decomposition:
- Shared package register_serial_pkg:
  - State typedef (IDLE, SHIFT).
  - Default ANCHO constant.
  - Function computing the counter width.
- Natural sub-module: contador_bits.
  - Synchronous-reset up-counter with clear, enable and terminal-count flag.
  - Instantiated for count; the terminal value is ANCHO-1, or ANCHO with PISO_PARITY_EN.

Test Plan:
- Reset release, no carga -> listo=1, valido=0, Q=0, fin=0 held for 5 cycles.
- ANCHO=8, In=8'hA5 pulsed with carga -> cycles 1..8 after accept show Q=1,0,1,0,0,1,0,1 with valido=1; fin=1 only on cycle 8; valido=0 on cycle 9.
- Back-to-back: 8'hA5 accepted, then carga=1 with In=8'h3C held during the fin cycle -> 16 contiguous valido cycles; bits 9..16 are 0,0,1,1,1,1,0,0.
- carga=1 with In=8'hFF on cycles 2..5 of an 8'h00 word -> eight Q=0 bits emitted; listo=0 until fin.
- reset=1 on the 3rd bit of 8'hA5 -> next edge valido=0, Q=0, listo=1; a fresh carga with 8'h81 emits 1,0,0,0,0,0,0,1.
- PISO_PARITY_EN defined:
  - 8'hA5 -> 9 bits, 9th=0, fin on the 9th.
  - 8'h07 -> 9th bit=1.
